// File: rtl/avl_resp_pkg.sv
// Shared types and defaults for the Avalon-MM memory responder.
package avl_resp_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    REFRESH = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH     = 26;
  localparam int unsigned DEF_DATA_WIDTH     = 128;
  localparam int unsigned DEF_MEM_WORDS_LOG2 = 10;
  localparam int unsigned DEF_READ_LATENCY   = 4;
  localparam int unsigned DEF_INIT_CYCLES    = 64;
  localparam int unsigned DEF_REFRESH_PERIOD = 512;
  localparam int unsigned DEF_REFRESH_CYCLES = 8;

  // Bits needed for a counter running 0 .. span-1 (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned span);
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/avl_resp_ram.sv
// Single-port backing RAM: byte-enabled synchronous write, combinational read.
module avl_resp_ram
  import avl_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WORDS_LOG2 = DEF_MEM_WORDS_LOG2
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [WORDS_LOG2-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata_c
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** WORDS_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/avl_mem_responder.sv
// Stand-in for the DDR3 controller local port: on-chip RAM, fixed read latency,
// calibration delay and periodic refresh stalls.
module avl_mem_responder
  import avl_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned MEM_WORDS_LOG2 = DEF_MEM_WORDS_LOG2,
  parameter int unsigned READ_LATENCY   = DEF_READ_LATENCY,
  parameter int unsigned INIT_CYCLES    = DEF_INIT_CYCLES,
  parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   avl_addr,
  input  logic [DATA_WIDTH-1:0]   avl_wdata,
  input  logic [DATA_WIDTH/8-1:0] avl_be,
  input  logic                    avl_read_req,
  input  logic                    avl_write_req,
  input  logic                    avl_burstbegin,
  output logic                    avl_ready,
  output logic [DATA_WIDTH-1:0]   avl_rdata,
  output logic                    avl_rdata_valid,
  output logic                    local_init_done,
  output logic                    proto_err
);

  localparam int unsigned INIT_W   = cnt_width(INIT_CYCLES);
  localparam int unsigned REF_SPAN = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD
                                                                       : REFRESH_CYCLES;
  localparam int unsigned REF_W    = cnt_width(REF_SPAN);

  state_t             state, state_n;
  logic [INIT_W-1:0]  init_cnt, init_cnt_n;
  logic [REF_W-1:0]   ref_cnt, ref_cnt_n;

  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_q_c;
  logic [READ_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0]   dat [READ_LATENCY];

  // Burst framing is ignored and high address bits alias away.
  logic unused_c;
  assign unused_c = ^{avl_burstbegin, avl_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2]};

  // A simultaneous read+write keeps the write and drops the read.
  assign wr_acc = avl_write_req && avl_ready;
  assign rd_acc = avl_read_req && avl_ready && !avl_write_req;

  avl_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS_LOG2 (MEM_WORDS_LOG2)
  ) u_ram (
    .clk     (clk),
    .we      (wr_acc),
    .be      (avl_be),
    .addr    (avl_addr[MEM_WORDS_LOG2-1:0]),
    .wdata   (avl_wdata),
    .rdata_c (ram_q_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= INIT;
      init_cnt        <= '0;
      ref_cnt         <= '0;
      avl_ready       <= 1'b0;
      local_init_done <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      state           <= state_n;
      init_cnt        <= init_cnt_n;
      ref_cnt         <= ref_cnt_n;
      avl_ready       <= (state_n == RUN);
      local_init_done <= local_init_done || (state_n == RUN);
      proto_err       <= proto_err || (avl_read_req && avl_write_req && avl_ready);
    end
  end

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    ref_cnt_n  = ref_cnt;
    case (state)
      INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_n = RUN;
        else init_cnt_n = init_cnt + INIT_W'(1);
      end
      RUN: begin
        if ((REFRESH_CYCLES != 0) && (ref_cnt == REF_W'(REFRESH_PERIOD - 1))) begin
          state_n   = REFRESH;
          ref_cnt_n = '0;
        end else begin
          ref_cnt_n = ref_cnt + REF_W'(1);
        end
      end
      REFRESH: begin
        if (ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
          state_n   = RUN;
          ref_cnt_n = '0;
        end else begin
          ref_cnt_n = ref_cnt + REF_W'(1);
        end
      end
      default: state_n = INIT;
    endcase
  end

  // Read pipeline: RAM word captured at accept; the last stage is the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= rd_acc;
      if (rd_acc) dat[0] <= ram_q_c;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign avl_rdata_valid = vld[READ_LATENCY-1];
  assign avl_rdata       = dat[READ_LATENCY-1];

endmodule

// File: tb/tb_avl_mem_responder.sv
// Scoreboard bench for avl_mem_responder: directed requests, monitor checks returned reads.
module tb_avl_mem_responder;

  localparam int unsigned AW  = 26;
  localparam int unsigned DW  = 128;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned LAT = 4;

  logic          clk;
  logic          reset;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic [BW-1:0] avl_be;
  logic          avl_read_req;
  logic          avl_write_req;
  logic          avl_burstbegin;
  logic          avl_ready;
  logic [DW-1:0] avl_rdata;
  logic          avl_rdata_valid;
  logic          local_init_done;
  logic          proto_err;

  avl_mem_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MEM_WORDS_LOG2 (10),
    .READ_LATENCY   (LAT),
    .INIT_CYCLES    (64),
    .REFRESH_PERIOD (512),
    .REFRESH_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avl_addr        (avl_addr),
    .avl_wdata       (avl_wdata),
    .avl_be          (avl_be),
    .avl_read_req    (avl_read_req),
    .avl_write_req   (avl_write_req),
    .avl_burstbegin  (avl_burstbegin),
    .avl_ready       (avl_ready),
    .avl_rdata       (avl_rdata),
    .avl_rdata_valid (avl_rdata_valid),
    .local_init_done (local_init_done),
    .proto_err       (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  localparam logic [DW-1:0] BEEF = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read, in data and cycle.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (avl_rdata_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got rdata %0h with no read outstanding (cycle %0d)",
                   avl_rdata, cyc);
        end else begin
          e = sb.pop_front();
          check("rdata_cycle", DW'(cyc), DW'(e.cyc));
          check("rdata", avl_rdata, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    avl_read_req  = 1'b0;
    avl_write_req = 1'b0;
    repeat (n) step();
  endtask

  // Present a request, hold it until ready, optionally record the expected read data.
  task automatic req(input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] b,
                     input logic [DW-1:0] exp_d, input bit push,
                     output int unsigned acc_cyc);
    int budget;
    exp_t e;
    budget        = 50;
    avl_read_req  = r;
    avl_write_req = w;
    avl_addr      = a;
    avl_wdata     = d;
    avl_be        = b;
    while (avl_ready !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: avl_ready=%b after 50 cycles, expected 1", avl_ready);
    end
    acc_cyc = cyc;
    if (push && r && !w) begin
      e.cyc  = cyc + LAT;
      e.data = exp_d;
      sb.push_back(e);
    end
    step();
  endtask

  initial begin
    int unsigned c0;
    int unsigned ac;
    reset          = 1'b1;
    avl_addr       = '0;
    avl_wdata      = '0;
    avl_be         = '0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_burstbegin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", avl_ready, 0);
    check("rst_valid", avl_rdata_valid, 0);
    check("rst_rdata", avl_rdata, 0);
    check("rst_init_done", local_init_done, 0);
    check("rst_proto_err", proto_err, 0);

    // Cycle 0 is the first cycle with reset low.
    reset = 1'b0;
    c0    = cyc;
    for (int i = 0; i <= 64; i++) begin
      check("init_ready", avl_ready, DW'(i == 64));
      check("init_done", local_init_done, DW'(i == 64));
      if (i < 64) step();
    end
    check("init_proto_err", proto_err, 0);

    // Read-after-write to the same address.
    req(1'b0, 1'b1, 26'h5, BEEF, 16'hFFFF, '0, 1'b0, ac);
    req(1'b1, 1'b0, 26'h5, '0, '0, BEEF, 1'b1, ac);
    idle(1);

    // Partial byte-enable overwrite.
    req(1'b0, 1'b1, 26'h9, {DW{1'b1}}, 16'hFFFF, '0, 1'b0, ac);
    req(1'b0, 1'b1, 26'h9, '0, 16'h000F, '0, 1'b0, ac);
    req(1'b1, 1'b0, 26'h9, '0, '0, {{96{1'b1}}, 32'h0}, 1'b1, ac);
    idle(1);

    // Preload 0..7, back-to-back reads, then an aliased address.
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, AW'(i), DW'(i), 16'hFFFF, '0, 1'b0, ac);
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, AW'(i), '0, '0, DW'(i), 1'b1, ac);
    req(1'b1, 1'b0, 26'h400, '0, '0, DW'(0), 1'b1, ac);
    idle(1);

    // Refresh window: RUN cycle k is relative cycle 64+k.
    while (cyc - c0 < 574) step();
    check("ready_run510", avl_ready, 1);
    req(1'b1, 1'b0, 26'h1, '0, '0, DW'(1), 1'b1, ac);
    check("accept_run510", DW'(ac - c0), DW'(574));
    avl_read_req = 1'b0;
    check("ready_run511", avl_ready, 1);
    step();
    check("ready_run512", avl_ready, 0);
    step();
    req(1'b1, 1'b0, 26'h2, '0, '0, DW'(2), 1'b1, ac);
    check("accept_run513_held", DW'(ac - c0), DW'(584));
    idle(1);
    check("ready_after_refresh", avl_ready, 1);

    // Simultaneous read and write: write lands, read dropped, sticky error.
    req(1'b1, 1'b1, 26'hA, 128'h1234, 16'hFFFF, '0, 1'b0, ac);
    idle(0);
    check("proto_err_set", proto_err, 1);
    req(1'b1, 1'b0, 26'hA, '0, '0, 128'h1234, 1'b1, ac);
    idle(6);
    check("proto_err_sticky", proto_err, 1);

    // Reset two cycles after a read accept kills the in-flight read.
    req(1'b1, 1'b0, 26'h3, '0, '0, '0, 1'b0, ac);
    idle(1);
    reset = 1'b1;
    step();
    check("midrst_valid", avl_rdata_valid, 0);
    check("midrst_proto_err", proto_err, 0);
    check("midrst_init_done", local_init_done, 0);
    check("midrst_ready", avl_ready, 0);
    step();
    reset = 1'b0;
    idle(8);
    check("sb_drained", DW'(sb.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
